// File: rtl/mem_access_pkg.sv
// Shared types for the MEM-stage load/store unit: op encodings, FSM states, helpers.
package mem_access_pkg;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned STRW = 4;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } mem_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    function automatic logic op_is_store(input logic [2:0] op);
        return op[2] & (op[1] | op[0]);
    endfunction

    function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] lane);
        logic mis;
        mis = 1'b0;
        case (mem_op_t'(op))
            OP_LH, OP_LHU, OP_SH: mis = lane[0];
            OP_LW, OP_SW:         mis = |lane;
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Pipeline-side and data-bus-side signals of the MEM-stage load/store unit.
interface mem_access_if;
    import mem_access_pkg::*;

    logic                  mem_en;
    logic [2:0]            mem_op;
    logic [AW-1:0]         addr;
    logic [DW-1:0]         wdata;
    logic                  flush;
    logic                  dreq;
    logic                  dwe;
    logic [AW-1:0]         daddr;
    logic [STRW-1:0]       dwstrb;
    logic [DW-1:0]         dwdata;
    logic                  dack;
    logic [DW-1:0]         drdata;
    logic [DW-1:0]         rdata;
    logic                  stall;
    logic                  adel;
    logic                  ades;
    logic [AW-1:0]         badvaddr;

    modport slave (
        input  mem_en, mem_op, addr, wdata, flush, dack, drdata,
        output dreq, dwe, daddr, dwstrb, dwdata, rdata, stall, adel, ades, badvaddr
    );

    modport master (
        output mem_en, mem_op, addr, wdata, flush, dack, drdata,
        input  dreq, dwe, daddr, dwstrb, dwdata, rdata, stall, adel, ades, badvaddr
    );
endinterface

// File: rtl/mem_access_load_ext.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_ext
    import mem_access_pkg::*;
(
    input  mem_op_t         op_i,
    input  logic [1:0]      lane_i,
    input  logic [DW-1:0]   drdata_i,
    output logic [DW-1:0]   ext_c_o
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        byte_c  = drdata_i[7:0];
        half_c  = lane_i[1] ? drdata_i[31:16] : drdata_i[15:0];
        ext_c_o = drdata_i;
        case (lane_i)
            2'd1:    byte_c = drdata_i[15:8];
            2'd2:    byte_c = drdata_i[23:16];
            2'd3:    byte_c = drdata_i[31:24];
            default: byte_c = drdata_i[7:0];
        endcase
        case (op_i)
            OP_LB:   ext_c_o = {{24{byte_c[7]}}, byte_c};
            OP_LBU:  ext_c_o = {24'd0, byte_c};
            OP_LH:   ext_c_o = {{16{half_c[15]}}, half_c};
            OP_LHU:  ext_c_o = {16'd0, half_c};
            default: ext_c_o = drdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM-stage load/store unit: issues one data-bus request per access, stalls the
// pipeline until completion, and handles misalignment, flush and drain.
module mem_access
    import mem_access_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    mem_access_if.slave  bus
);

    state_t               state_q, state_d;
    logic                 dreq_q, dreq_d;
    logic                 dwe_q, dwe_d;
    logic [AW-1:0]        daddr_q, daddr_d;
    logic [STRW-1:0]      dwstrb_q, dwstrb_d;
    logic [DW-1:0]        dwdata_q, dwdata_d;
    logic [DW-1:0]        rdata_q, rdata_d;
    mem_op_t              op_q, op_d;
    logic [1:0]           lane_q, lane_d;

    mem_op_t              op_c;
    logic                 misalign_c;
    logic                 issue_c;
    logic                 stall_c;
    logic [STRW-1:0]      strb_c;
    logic [DW-1:0]        wdat_c;
    logic [DW-1:0]        ext_c;

    assign op_c       = mem_op_t'(bus.mem_op);
    assign misalign_c = bus.mem_en && op_misaligned(bus.mem_op, bus.addr[1:0]);
    assign issue_c    = (state_q == S_IDLE) && bus.mem_en && !misalign_c && !bus.flush;

    // Extension uses the op and lane captured at issue, not the live pipeline inputs.
    load_ext u_load_ext (
        .op_i     (op_q),
        .lane_i   (lane_q),
        .drdata_i (bus.drdata),
        .ext_c_o  (ext_c)
    );

    // Store lane strobes and replicated write data.
    always_comb begin
        strb_c = '0;
        wdat_c = '0;
        case (op_c)
            OP_SB: begin
                strb_c = 4'b0001 << bus.addr[1:0];
                wdat_c = {4{bus.wdata[7:0]}};
            end
            OP_SH: begin
                strb_c = bus.addr[1] ? 4'b1100 : 4'b0011;
                wdat_c = {2{bus.wdata[15:0]}};
            end
            OP_SW: begin
                strb_c = 4'b1111;
                wdat_c = bus.wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        dreq_d   = dreq_q;
        dwe_d    = dwe_q;
        daddr_d  = daddr_q;
        dwstrb_d = dwstrb_q;
        dwdata_d = dwdata_q;
        rdata_d  = rdata_q;
        op_d     = op_q;
        lane_d   = lane_q;
        stall_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (issue_c) begin
                    dreq_d   = 1'b1;
                    dwe_d    = op_is_store(bus.mem_op);
                    daddr_d  = {bus.addr[AW-1:2], 2'b00};
                    dwstrb_d = strb_c;
                    dwdata_d = wdat_c;
                    op_d     = op_c;
                    lane_d   = bus.addr[1:0];
                    stall_c  = 1'b1;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                stall_c = 1'b1;
                if (bus.flush) begin
                    if (bus.dack) begin
                        dreq_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (bus.dack) begin
                    if (!op_is_store(op_q)) begin
                        rdata_d = ext_c;
                    end
                    dreq_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                // A flushed request must still complete on the bus; only the new instruction waits.
                stall_c = bus.mem_en;
                if (bus.dack) begin
                    dreq_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            dreq_q   <= 1'b0;
            dwe_q    <= 1'b0;
            daddr_q  <= '0;
            dwstrb_q <= '0;
            dwdata_q <= '0;
            rdata_q  <= '0;
            op_q     <= OP_LB;
            lane_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            dreq_q   <= dreq_d;
            dwe_q    <= dwe_d;
            daddr_q  <= daddr_d;
            dwstrb_q <= dwstrb_d;
            dwdata_q <= dwdata_d;
            rdata_q  <= rdata_d;
            op_q     <= op_d;
            lane_q   <= lane_d;
        end
    end

    assign bus.dreq     = dreq_q;
    assign bus.dwe      = dwe_q;
    assign bus.daddr    = daddr_q;
    assign bus.dwstrb   = dwstrb_q;
    assign bus.dwdata   = dwdata_q;
    assign bus.rdata    = rdata_q;
    assign bus.stall    = stall_c;
    assign bus.adel     = misalign_c && (state_q == S_IDLE) && !op_is_store(bus.mem_op);
    assign bus.ades     = misalign_c && (state_q == S_IDLE) && op_is_store(bus.mem_op);
    assign bus.badvaddr = bus.addr;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: expected bus/rdata pushed at issue, popped on completion.
module tb_mem_access;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    mem_access_if bus ();

    mem_access dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        dwe;
        logic [31:0] daddr;
        logic [3:0]  strb;
        logic [31:0] wd;
        logic [31:0] rd;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] cur_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] m_load(input logic [2:0] op, input logic [1:0] a,
                                           input logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        b = d >> {a, 3'b000};
        h = d >> {a[1], 4'b0000};
        case (op)
            3'd0:    return {{24{b[7]}}, b[7:0]};
            3'd1:    return {24'd0, b[7:0]};
            3'd2:    return {{16{h[15]}}, h[15:0]};
            3'd3:    return {16'd0, h[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic exp_t m_expect(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] w, input logic [31:0] d);
        exp_t e;
        e.dwe   = (op >= 3'd5);
        e.daddr = {a[31:2], 2'b00};
        e.strb  = 4'b0000;
        e.wd    = 32'd0;
        e.rd    = e.dwe ? cur_rdata : m_load(op, a[1:0], d);
        case (op)
            3'd5: begin
                case (a[1:0])
                    2'd0: e.strb = 4'b0001;
                    2'd1: e.strb = 4'b0010;
                    2'd2: e.strb = 4'b0100;
                    default: e.strb = 4'b1000;
                endcase
                e.wd = {w[7:0], w[7:0], w[7:0], w[7:0]};
            end
            3'd6: begin
                e.strb = a[1] ? 4'b1100 : 4'b0011;
                e.wd   = {w[15:0], w[15:0]};
            end
            3'd7: begin
                e.strb = 4'b1111;
                e.wd   = w;
            end
            default: ;
        endcase
        return e;
    endfunction

    // Full access: issue, lat extra WAIT cycles, dack, DONE. scramble perturbs live op/addr while waiting.
    task automatic do_access(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w,
                             input logic [31:0] d, input int lat, input bit scramble);
        exp_t e;
        sb.push_back(m_expect(op, a, w, d));
        bus.mem_en = 1'b1;
        bus.mem_op = op;
        bus.addr   = a;
        bus.wdata  = w;
        bus.flush  = 1'b0;
        bus.dack   = 1'b0;
        #1;
        chk("issue_stall", 32'(bus.stall), 32'd1);
        tick();
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk("dreq", 32'(bus.dreq), 32'd1);
        chk("dwe", 32'(bus.dwe), 32'(e.dwe));
        chk("daddr", bus.daddr, e.daddr);
        if (e.dwe) begin
            chk("dwstrb", 32'(bus.dwstrb), 32'(e.strb));
            chk("dwdata", bus.dwdata, e.wd);
        end
        if (scramble) begin
            bus.addr   = a ^ 32'h0000_0003;
            bus.mem_op = 3'd4;
        end
        for (int i = 0; i < lat; i++) begin
            #1;
            chk("wait_stall", 32'(bus.stall), 32'd1);
            tick();
            chk("wait_dreq", 32'(bus.dreq), 32'd1);
            chk("wait_daddr", bus.daddr, e.daddr);
        end
        bus.dack   = 1'b1;
        bus.drdata = d;
        #1;
        chk("ack_stall", 32'(bus.stall), 32'd1);
        tick();
        bus.dack   = 1'b0;
        bus.drdata = $urandom;
        #1;
        chk("done_stall", 32'(bus.stall), 32'd0);
        chk("done_dreq", 32'(bus.dreq), 32'd0);
        chk("rdata", bus.rdata, e.rd);
        cur_rdata  = e.rd;
        bus.mem_en = 1'b0;
        bus.addr   = a;
        bus.mem_op = op;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        total      = 0;
        bad        = 0;
        cur_rdata  = 32'd0;
        reset      = 1'b1;
        bus.mem_en = 1'b0;
        bus.mem_op = 3'd0;
        bus.addr   = 32'd0;
        bus.wdata  = 32'd0;
        bus.flush  = 1'b0;
        bus.dack   = 1'b0;
        bus.drdata = 32'd0;
        tick();
        tick();
        chk("rst_dreq", 32'(bus.dreq), 32'd0);
        chk("rst_dwe", 32'(bus.dwe), 32'd0);
        chk("rst_daddr", bus.daddr, 32'd0);
        chk("rst_dwstrb", 32'(bus.dwstrb), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        reset = 1'b0;
        tick();

        do_access(3'd4, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 0, 1'b0);
        do_access(3'd0, 32'h0000_0103, 32'd0, 32'h8011_2233, 1, 1'b1);
        do_access(3'd1, 32'h0000_0103, 32'd0, 32'h8011_2233, 0, 1'b0);
        do_access(3'd6, 32'h0000_0202, 32'h1234_ABCD, 32'h1111_1111, 0, 1'b0);
        do_access(3'd5, 32'h0000_0101, 32'h0000_005A, 32'h2222_2222, 2, 1'b0);
        do_access(3'd2, 32'h0000_0102, 32'd0, 32'h8001_4242, 0, 1'b1);
        do_access(3'd3, 32'h0000_0102, 32'd0, 32'h8001_4242, 1, 1'b0);
        do_access(3'd2, 32'h0000_0100, 32'd0, 32'h1234_7FFF, 0, 1'b0);
        do_access(3'd7, 32'h0000_0204, 32'hCAFE_F00D, 32'h3333_3333, 3, 1'b0);
        do_access(3'd0, 32'h0000_0101, 32'd0, 32'h0000_FF00, 0, 1'b0);

        // misaligned accesses raise an exception and issue nothing
        bus.mem_en = 1'b1;
        bus.mem_op = 3'd4;
        bus.addr   = 32'h0000_0101;
        #1;
        chk("adel_lw", 32'(bus.adel), 32'd1);
        chk("adel_ades", 32'(bus.ades), 32'd0);
        chk("adel_bva", bus.badvaddr, 32'h0000_0101);
        chk("adel_stall", 32'(bus.stall), 32'd0);
        tick();
        chk("adel_dreq", 32'(bus.dreq), 32'd0);
        bus.mem_op = 3'd6;
        bus.addr   = 32'h0000_0203;
        #1;
        chk("ades_sh", 32'(bus.ades), 32'd1);
        chk("ades_adel", 32'(bus.adel), 32'd0);
        chk("ades_bva", bus.badvaddr, 32'h0000_0203);
        bus.mem_op = 3'd3;
        bus.addr   = 32'h0000_0206;
        #1;
        chk("aligned_lhu_adel", 32'(bus.adel), 32'd0);
        chk("aligned_lhu_stall", 32'(bus.stall), 32'd1);
        bus.mem_en = 1'b0;
        tick();
        chk("noissue_dreq", 32'(bus.dreq), 32'd0);

        // flush in IDLE suppresses issue
        bus.mem_en = 1'b1;
        bus.mem_op = 3'd4;
        bus.addr   = 32'h0000_0600;
        bus.flush  = 1'b1;
        #1;
        chk("iflush_stall", 32'(bus.stall), 32'd0);
        tick();
        chk("iflush_dreq", 32'(bus.dreq), 32'd0);
        bus.flush  = 1'b0;
        bus.mem_en = 1'b0;
        tick();

        // flush in WAIT, dack three cycles later -> DRAIN then IDLE, data discarded
        bus.mem_en = 1'b1;
        bus.mem_op = 3'd4;
        bus.addr   = 32'h0000_0400;
        tick();
        chk("fw_dreq", 32'(bus.dreq), 32'd1);
        bus.flush = 1'b1;
        #1;
        chk("fw_stall", 32'(bus.stall), 32'd1);
        tick();
        bus.flush  = 1'b0;
        bus.mem_en = 1'b0;
        #1;
        chk("drain_stall0", 32'(bus.stall), 32'd0);
        chk("drain_dreq", 32'(bus.dreq), 32'd1);
        tick();
        bus.mem_en = 1'b1;
        #1;
        chk("drain_stall1", 32'(bus.stall), 32'd1);
        bus.mem_en = 1'b0;
        tick();
        chk("drain_hold", 32'(bus.dreq), 32'd1);
        bus.dack   = 1'b1;
        bus.drdata = 32'h9999_9999;
        tick();
        bus.dack = 1'b0;
        #1;
        chk("drain_end_dreq", 32'(bus.dreq), 32'd0);
        chk("drain_rdata", bus.rdata, cur_rdata);
        chk("drain_end_stall", 32'(bus.stall), 32'd0);
        tick();
        chk("drain_idle_dreq", 32'(bus.dreq), 32'd0);

        // flush and dack together in WAIT -> straight to IDLE
        bus.mem_en = 1'b1;
        bus.mem_op = 3'd4;
        bus.addr   = 32'h0000_0500;
        tick();
        bus.flush  = 1'b1;
        bus.dack   = 1'b1;
        bus.drdata = 32'h7777_7777;
        bus.mem_en = 1'b0;
        tick();
        bus.flush = 1'b0;
        bus.dack  = 1'b0;
        #1;
        chk("fack_dreq", 32'(bus.dreq), 32'd0);
        chk("fack_rdata", bus.rdata, cur_rdata);
        chk("fack_stall", 32'(bus.stall), 32'd0);
        tick();
        chk("fack_idle_dreq", 32'(bus.dreq), 32'd0);

        // reset in WAIT abandons the request; late dack ignored
        bus.mem_en = 1'b1;
        bus.mem_op = 3'd4;
        bus.addr   = 32'h0000_0300;
        tick();
        chk("rw_dreq", 32'(bus.dreq), 32'd1);
        reset      = 1'b1;
        bus.mem_en = 1'b0;
        tick();
        chk("rw_dreq0", 32'(bus.dreq), 32'd0);
        chk("rw_rdata0", bus.rdata, 32'd0);
        chk("rw_daddr0", bus.daddr, 32'd0);
        reset      = 1'b0;
        cur_rdata  = 32'd0;
        bus.dack   = 1'b1;
        bus.drdata = 32'h5555_5555;
        tick();
        bus.dack = 1'b0;
        #1;
        chk("late_rdata", bus.rdata, 32'd0);
        chk("late_dreq", 32'(bus.dreq), 32'd0);
        chk("late_stall", 32'(bus.stall), 32'd0);
        tick();

        // random aligned traffic
        for (int n = 0; n < 12; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            if (rop == 3'd2 || rop == 3'd3 || rop == 3'd6) ra[0] = 1'b0;
            if (rop == 3'd4 || rop == 3'd7) ra[1:0] = 2'b00;
            do_access(rop, ra, $urandom, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
